uart_cmd_rx: RTL and testbench
==============================

// Module: uart_cmd_rx
// PURPOSE
//   UART receiver and command assembler; counterpart of the command transmitter on the same serial link.
//   Samples the rx line, decodes 8N1 frames (optionally with odd parity) and packs consecutive bytes, MSB byte first, into CMD_WIDTH-bit commands.
//   Presents each command on a valid/ready handshake to the downstream command decoder.
//   Reports parity errors, framing errors and overruns as single-cycle pulses.
// PARAMETERS
//   CLK_FREQ   50000000  system clock frequency, Hz
//   BAUD       115200    line rate; BIT_CNT = CLK_FREQ/BAUD (integer division, 434 at defaults)
//   CMD_WIDTH  16        command width; must be a multiple of 8; NBYTES = CMD_WIDTH/8
//   PARITY_EN  1         1: a parity bit follows the data bits, odd parity (bit = ~^data); 0: no parity bit
// PORTS
//   clk         in   1          system clock, rising edge
//   rst_n       in   1          reset, asynchronous, active-low
//   rx          in   1          serial input, idle high, asynchronous to clk
//   cmd_out     out  CMD_WIDTH  assembled command; first received byte in [CMD_WIDTH-1:CMD_WIDTH-8]
//   cmd_vld     out  1          cmd_out valid; held until accepted
//   cmd_rdy     in   1          downstream accepts cmd_out when cmd_vld && cmd_rdy at a rising edge
//   parity_err  out  1          1-cycle pulse: received parity bit mismatched
//   frame_err   out  1          1-cycle pulse: stop bit sampled low
//   overrun     out  1          1-cycle pulse: a completed command was dropped because cmd_vld was still high
// BEHAVIOUR
//   - Reset: all outputs 0; FSM in IDLE; byte index 0; synchroniser flops 1; counters 0.
//   - rx passes through a 2-flop synchroniser (reset value 1); all decoding uses the synchronised value rxs.
//   - FSM states:
//     - IDLE: a high-to-low edge on rxs -> START, baud counter cleared.
//     - START: at count BIT_CNT/2-1, rxs low -> DATA; rxs high -> IDLE (glitch rejected, no error).
//     - DATA: sample at each BIT_CNT, i.e. mid-bit, LSB first; after 8 bits -> PARITY if PARITY_EN, else STOP.
//     - PARITY: sample one bit; mismatch sets an internal error flag. Then -> STOP.
//     - STOP: sample one bit.
//       - Low: frame_err pulses, byte discarded; FSM -> BREAK.
//       - High with the parity flag set: parity_err pulses, byte discarded; -> IDLE.
//       - High and clean: byte stored; -> IDLE.
//     - BREAK: wait until rxs high, then -> IDLE.
//   - Any error (parity or frame) resets the byte index to 0; the partial command is discarded.
//   - Byte index counts 0..NBYTES-1 and wraps to 0 when the last byte is stored.
//   - Command completion: cmd_out and cmd_vld update 1 cycle after the stop-bit sample of byte NBYTES-1.
//   - While cmd_vld=1, cmd_out is stable. cmd_vld clears on the cycle after the handshake (vld && rdy).
//   - Simultaneous events:
//     - If completion and handshake fall in the same cycle, the old command is accepted and the new one loaded; cmd_vld stays 1, no overrun.
//     - If completion occurs with cmd_vld=1 and cmd_rdy=0, the new command is dropped, overrun pulses and cmd_out is unchanged.
//   - Error pulses are mutually exclusive per byte. Frame error takes priority over parity error.
//   - Reset asserted mid-frame: immediate return to the reset state; the partial byte and partial command are lost.
// CONFIGURATION
//   UART_RX_TIMEOUT_EN defined:
//     - An inter-byte timer runs in IDLE while byte index != 0.
//     - If 2*NBYTES*11*BIT_CNT cycles elapse with no start bit, the byte index resets to 0 and the partial command is discarded silently.
//     - The timer clears on each start edge.
//   UART_RX_TIMEOUT_EN undefined: no timer; a partial command waits indefinitely for its remaining bytes.
// TESTING
//   (sim: CLK_FREQ=1000000, BAUD=100000 -> BIT_CNT=10; PARITY_EN=1 unless noted)
//   - Bytes 0xA5, 0x3C with correct parity, cmd_rdy=1 -> cmd_out=0xA53C, cmd_vld high exactly 1 cycle, no error pulses.
//   - 0x12, 0x34 with cmd_rdy=0, then 0x56, 0x78 -> cmd_out stays 0x1234, overrun pulses once. Then raise cmd_rdy -> cmd_vld falls.
//   - 0xFF with a wrong parity bit, then 0x01, 0x02 -> parity_err pulses once; the next command is 0x0102.
//   - 0x55 with stop bit 0 and rx held low 30 cycles, then 0xAB, 0xCD -> frame_err pulses once; the next command is 0xABCD.
//   - 4-cycle low glitch on idle rx -> no state change, no outputs. Also: assert rst_n mid-byte -> all outputs 0, and the next clean 2 bytes decode correctly.
//   - UART_RX_TIMEOUT_EN: send 0x11, idle 500 cycles, then 0x22, 0x33 -> cmd_out=0x2233. Without the macro, the same stimulus gives 0x1122.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver (optional odd parity) packing bytes MSB-first into CMD_WIDTH-bit commands on valid/ready.
// Define UART_RX_TIMEOUT_EN to discard partial commands after an inter-byte idle timeout.
module uart_cmd_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int CMD_WIDTH = 16,
  parameter int PARITY_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [CMD_WIDTH-1:0] cmd_out,
  output logic                 cmd_vld,
  input  logic                 cmd_rdy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int NBYTES  = CMD_WIDTH / 8;
  localparam int CW      = (BIT_CNT > 2) ? $clog2(BIT_CNT) : 1;
  localparam int BW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CNT / 2 - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_CYCLES = 2 * NBYTES * 11 * BIT_CNT;
  localparam int TW        = $clog2(TO_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);
  logic [TW-1:0] to_cnt;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state;
  logic                 rx_meta, rxs, rxs_d;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           data_sr;
  logic                 par_bad;
  logic [BW-1:0]        byte_idx;
  logic [CMD_WIDTH-1:0] cmd_sr;
  logic                 cmd_done;
  logic                 fall;

  assign fall = rxs_d & ~rxs;

  // Synchroniser resets to the idle-high line level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so each flop captures the pre-edge value of its neighbour.
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      data_sr    <= '0;
      par_bad    <= 1'b0;
      byte_idx   <= '0;
      cmd_sr     <= '0;
      cmd_done   <= 1'b0;
      cmd_out    <= '0;
      cmd_vld    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      cmd_done   <= 1'b0;

      // A completion coinciding with a handshake replaces the accepted command without a gap.
      if (cmd_done) begin
        if (!cmd_vld || cmd_rdy) begin
          cmd_out <= cmd_sr;
          cmd_vld <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (cmd_vld && cmd_rdy) begin
        cmd_vld <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (fall) begin
            state <= S_START;
`ifdef UART_RX_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
`ifdef UART_RX_TIMEOUT_EN
          else if (byte_idx != '0) begin
            if (to_cnt == TO_LAST) begin
              to_cnt   <= '0;
              byte_idx <= '0;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end else begin
            to_cnt <= '0;
          end
`endif
        end

        S_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            par_bad  <= 1'b0;
            state    <= rxs ? S_IDLE : S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            data_sr  <= {rxs, data_sr[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        S_PARITY: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            par_bad  <= (rxs != ~^data_sr);
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            state    <= S_IDLE;
            if (!rxs) begin
              frame_err <= 1'b1;
              byte_idx  <= '0;
              state     <= S_BREAK;
            end else if (par_bad) begin
              parity_err <= 1'b1;
              byte_idx   <= '0;
            end else begin
              cmd_sr <= CMD_WIDTH'({cmd_sr, data_sr});
              if (byte_idx == BYTE_LAST) begin
                byte_idx <= '0;
                cmd_done <= 1'b1;
              end else begin
                byte_idx <= byte_idx + BW'(1);
              end
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        S_BREAK: begin
          if (rxs) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: directed link scenarios plus randomized bytes against a byte-level model.
// Expectations for the timeout scenario follow UART_RX_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_uart_cmd_rx;

  localparam int CLK_FREQ  = 1000000;
  localparam int BAUD      = 100000;
  localparam int BIT_CNT   = CLK_FREQ / BAUD;
  localparam int CMD_WIDTH = 16;
  localparam int NBYTES    = CMD_WIDTH / 8;
  localparam int PARITY_EN = 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 rx = 1'b1;
  logic                 cmd_rdy = 1'b0;
  logic [CMD_WIDTH-1:0] cmd_out;
  logic                 cmd_vld;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  uart_cmd_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .CMD_WIDTH(CMD_WIDTH),
    .PARITY_EN(PARITY_EN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .cmd_out   (cmd_out),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: bytes of the command being assembled, expected accepted commands, expected pulse counts.
  logic [7:0]           part_q[$];
  logic [CMD_WIDTH-1:0] exp_q[$];
  logic [CMD_WIDTH-1:0] got_q[$];
  bit                   slot_full = 1'b0;
  int exp_par = 0, exp_frame = 0, exp_ovr = 0;
  int par_cnt = 0, frame_cnt = 0, ovr_cnt = 0, vld_cycles = 0, both_cnt = 0;

  logic                 prev_vld = 1'b0;
  logic                 prev_hs  = 1'b0;
  logic [CMD_WIDTH-1:0] prev_cmd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe outputs mid-low-phase, well clear of the rising edge.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (cmd_vld && cmd_rdy) got_q.push_back(cmd_out);
      if (cmd_vld) vld_cycles++;
      if (parity_err) par_cnt++;
      if (frame_err) frame_cnt++;
      if (overrun) ovr_cnt++;
      if (parity_err && frame_err) both_cnt++;
      if (prev_vld && !prev_hs && cmd_vld) check("cmd_stable", 32'(cmd_out), 32'(prev_cmd));
      prev_vld = cmd_vld;
      prev_hs  = cmd_vld & cmd_rdy;
      prev_cmd = cmd_out;
    end else begin
      prev_vld = 1'b0;
      prev_hs  = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic model_complete(input logic [CMD_WIDTH-1:0] c);
    if (slot_full && !cmd_rdy) begin
      exp_ovr++;
    end else begin
      exp_q.push_back(c);
      slot_full = !cmd_rdy;
    end
  endtask

  task automatic model_byte(input logic [7:0] d, input bit bad_par, input bit stop_bit);
    logic [CMD_WIDTH-1:0] c;
    if (!stop_bit) begin
      exp_frame++;
      part_q.delete();
    end else if (PARITY_EN != 0 && bad_par) begin
      exp_par++;
      part_q.delete();
    end else begin
      part_q.push_back(d);
      if (part_q.size() == NBYTES) begin
        c = '0;
        foreach (part_q[i]) c = (c << 8) | CMD_WIDTH'(part_q[i]);
        part_q.delete();
        model_complete(c);
      end
    end
  endtask

  task automatic model_reset();
    part_q.delete();
    exp_q.delete();
    got_q.delete();
    slot_full = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CNT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit bad_par = 1'b0, input bit stop_bit = 1'b1,
                           input int hold_low = 0, input int gap = 4);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PARITY_EN != 0) drive_bit((~^d) ^ bad_par);
    drive_bit(stop_bit);
    if (!stop_bit) begin
      rx = 1'b0;
      repeat (hold_low) @(negedge clk);
    end
    rx = 1'b1;
    repeat (gap) @(negedge clk);
    model_byte(d, bad_par, stop_bit);
  endtask

  task automatic checkpoint(input string tag);
    int n;
    repeat (30) @(negedge clk);
    check({tag, "_ncmd"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_cmd"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    check({tag, "_parity_cnt"}, 32'(par_cnt), 32'(exp_par));
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frame));
    check({tag, "_overrun_cnt"}, 32'(ovr_cnt), 32'(exp_ovr));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cmd_out"}, 32'(cmd_out), 32'h0);
    check({tag, "_cmd_vld"}, 32'(cmd_vld), 32'h0);
    check({tag, "_parity_err"}, 32'(parity_err), 32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
  endtask

  task automatic apply_reset();
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    model_reset();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int v0;
    int r;
    logic [7:0] d;

    repeat (2) @(negedge clk);
    check_outputs_zero("por");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic command, ready held high.
    cmd_rdy = 1'b1;
    v0 = vld_cycles;
    send_byte(8'hA5);
    send_byte(8'h3C);
    checkpoint("basic");
    check("basic_vld_cycles", 32'(vld_cycles - v0), 32'd1);

    // Overrun while the first command is held.
    cmd_rdy = 1'b0;
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    check("ovr_cmd_held", 32'(cmd_out), 32'h1234);
    check("ovr_vld_held", 32'(cmd_vld), 32'h1);
    cmd_rdy   = 1'b1;
    slot_full = 1'b0;
    repeat (3) @(negedge clk);
    check("ovr_vld_cleared", 32'(cmd_vld), 32'h0);
    checkpoint("overrun");

    // Parity error discards the byte and resynchronises the byte index.
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01);
    send_byte(8'h02);
    checkpoint("parity");

    // Framing error with a held break.
    send_byte(8'h55, 1'b0, 1'b0, 30);
    send_byte(8'hAB);
    send_byte(8'hCD);
    checkpoint("frame");

    // Short glitch on an idle line must be ignored.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    checkpoint("glitch");
    send_byte(8'h5A);
    send_byte(8'hC3);
    checkpoint("post_glitch");

    // Reset in the middle of a byte while a command is pending.
    cmd_rdy = 1'b0;
    send_byte(8'h9A);
    send_byte(8'hBC);
    check("pre_reset_vld", 32'(cmd_vld), 32'h1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    apply_reset();
    cmd_rdy = 1'b1;
    send_byte(8'hDE);
    send_byte(8'hAD);
    checkpoint("post_reset");

    // Long inter-byte idle: partial command dropped only with the timeout feature.
    send_byte(8'h11, 1'b0, 1'b1, 0, 500);
`ifdef UART_RX_TIMEOUT_EN
    part_q.delete();
`endif
    send_byte(8'h22);
    send_byte(8'h33);
    checkpoint("timeout");
    apply_reset();
    par_cnt = 0; frame_cnt = 0; ovr_cnt = 0;
    exp_par = 0; exp_frame = 0; exp_ovr = 0;

    // Randomized bytes with occasional parity and framing errors.
    cmd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      d = 8'($urandom);
      send_byte(d, r == 0, r != 1, $urandom_range(0, 20), $urandom_range(3, 20));
    end
    checkpoint("random");

    check("err_exclusive", 32'(both_cnt), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
